// File: rtl/l2_input_arbiter_pkg.sv
// Shared types and defaults for the L2 input arbiter: source encoding, one-hot grant, FSM states.
package l2_input_arbiter_pkg;

  localparam int L2_STARVE_LIMIT = 8;
  localparam int L2_BUSY_TIMEOUT = 1024;

  // Enum value doubles as the grant bit position.
  typedef enum logic [2:0] {
    SRC_RSP = 3'd0,
    SRC_FWD = 3'd1,
    SRC_OFL = 3'd2,
    SRC_FNC = 3'd3,
    SRC_FL  = 3'd4,
    SRC_CPU = 3'd5
  } arb_src_t;

  typedef logic [5:0] grant_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  function automatic grant_t src_onehot(input arb_src_t src);
    return grant_t'(6'd1 << src);
  endfunction

endpackage

// File: rtl/l2_arb_starve_ctr.sv
// Saturating up-counter with increment/clear controls; used for cpu starvation and the busy timer.
module l2_arb_starve_ctr #(
  parameter int LIMIT = 8,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat_o = (cnt_q == CNT_W'(LIMIT));

  // Clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/l2_input_arbiter.sv
// Selects one L2 pipeline operation at a time with fixed priority, blocking terms and cpu anti-starvation.
module l2_input_arbiter
  import l2_input_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = L2_STARVE_LIMIT,
  parameter int BUSY_TIMEOUT = L2_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_in_valid,
  input  logic       fwd_in_valid,
  input  logic       cpu_req_valid,
  input  logic       flush_valid,
  input  logic       fence_valid,
  input  logic       fwd_stall,
  input  logic       set_conflict,
  input  logic       evict_stall,
  input  logic       ongoing_atomic,
  input  logic       ongoing_flush,
  input  logic       ongoing_fence,
  input  logic       mshr_full,
  input  logic       mshr_empty,
  input  logic       core_done,
  output logic       rsp_in_ready,
  output logic       fwd_in_ready,
  output logic       cpu_req_ready,
  output logic       flush_ready,
  output logic       fence_ready,
  output logic [5:0] grant,
  output logic       busy,
  output logic       err_timeout
);

  arb_state_t state_q;
  grant_t     grant_q;
  logic       busy_q;
  logic       err_q;

  logic rsp_el, fwd_el, ofl_el, fnc_el, fl_el, cpu_el;
  logic starve_sat, tmo_sat, cpu_promote;
  logic any_el, arb_go;
  arb_src_t win_src;

  assign rsp_el = rsp_in_valid;
  assign fwd_el = fwd_in_valid & ~fwd_stall;
  assign ofl_el = ongoing_flush & ~evict_stall;
  assign fnc_el = fence_valid & mshr_empty & ~ongoing_flush & ~ongoing_atomic;
  assign fl_el  = flush_valid & mshr_empty & ~ongoing_flush & ~ongoing_atomic;
  assign cpu_el = cpu_req_valid &
                  ~(set_conflict | evict_stall | mshr_full | ongoing_flush | ongoing_fence);

  // A starved cpu request jumps everything except responses.
  assign cpu_promote = cpu_el & starve_sat;

  always_comb begin
    win_src = SRC_RSP;
    any_el  = 1'b1;
    if (rsp_el)           win_src = SRC_RSP;
    else if (cpu_promote) win_src = SRC_CPU;
    else if (fwd_el)      win_src = SRC_FWD;
    else if (ofl_el)      win_src = SRC_OFL;
    else if (fnc_el)      win_src = SRC_FNC;
    else if (fl_el)       win_src = SRC_FL;
    else if (cpu_el)      win_src = SRC_CPU;
    else                  any_el  = 1'b0;
  end

  assign arb_go = (state_q == ST_IDLE) & any_el;

  assign rsp_in_ready  = arb_go & (win_src == SRC_RSP);
  assign fwd_in_ready  = arb_go & (win_src == SRC_FWD);
  assign fence_ready   = arb_go & (win_src == SRC_FNC);
  assign flush_ready   = arb_go & (win_src == SRC_FL);
  assign cpu_req_ready = arb_go & (win_src == SRC_CPU);

  l2_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (arb_go & cpu_el & (win_src != SRC_CPU)),
    .clr_i (cpu_req_ready | ~cpu_req_valid),
    .sat_o (starve_sat)
  );

  l2_arb_starve_ctr #(.LIMIT(BUSY_TIMEOUT)) u_busy_timer (
    .clk   (clk),
    .rst   (rst),
    .inc_i (state_q == ST_BUSY),
    .clr_i (state_q == ST_IDLE),
    .sat_o (tmo_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_q | tmo_sat;
      case (state_q)
        ST_IDLE: begin
          if (any_el) begin
            grant_q <= src_onehot(win_src);
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (core_done) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_l2_input_arbiter.sv
// Bench for l2_input_arbiter: vector table plus hand-written multi-cycle sequences, grant scoreboard.
module tb_l2_input_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic rsp_in_valid, fwd_in_valid, cpu_req_valid, flush_valid, fence_valid;
  logic fwd_stall, set_conflict, evict_stall, ongoing_atomic, ongoing_flush;
  logic ongoing_fence, mshr_full, mshr_empty, core_done;
  logic rsp_in_ready, fwd_in_ready, cpu_req_ready, flush_ready, fence_ready;
  logic [5:0] grant;
  logic busy, err_timeout;
  logic [4:0] rdy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  // Input record order: {rsp,fwd,cpu,flush,fence, fwd_stall,set_conflict,evict_stall,
  // ongoing_atomic,ongoing_flush,ongoing_fence,mshr_full,mshr_empty}
  typedef struct packed {
    logic [12:0] in;
    logic [4:0]  rdy;
    logic [5:0]  gnt;
  } vec_t;

  vec_t tbl[17];

  l2_input_arbiter dut (
    .clk(clk), .rst(rst),
    .rsp_in_valid(rsp_in_valid), .fwd_in_valid(fwd_in_valid), .cpu_req_valid(cpu_req_valid),
    .flush_valid(flush_valid), .fence_valid(fence_valid), .fwd_stall(fwd_stall),
    .set_conflict(set_conflict), .evict_stall(evict_stall), .ongoing_atomic(ongoing_atomic),
    .ongoing_flush(ongoing_flush), .ongoing_fence(ongoing_fence), .mshr_full(mshr_full),
    .mshr_empty(mshr_empty), .core_done(core_done),
    .rsp_in_ready(rsp_in_ready), .fwd_in_ready(fwd_in_ready), .cpu_req_ready(cpu_req_ready),
    .flush_ready(flush_ready), .fence_ready(fence_ready),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  assign rdy = {cpu_req_ready, flush_ready, fence_ready, fwd_in_ready, rsp_in_ready};

  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (!$onehot0(grant)) begin
        n_fail++;
        $display("FAIL grant_onehot: got %b, required at most one bit set", grant);
      end
    end
  end

  function automatic vec_t mk(input logic [12:0] in, input logic [4:0] r, input logic [5:0] g);
    vec_t v;
    v.in = in; v.rdy = r; v.gnt = g;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic apply_in(input logic [12:0] v);
    {rsp_in_valid, fwd_in_valid, cpu_req_valid, flush_valid, fence_valid,
     fwd_stall, set_conflict, evict_stall, ongoing_atomic, ongoing_flush,
     ongoing_fence, mshr_full, mshr_empty} = v;
  endtask

  task automatic set_idle();
    apply_in(13'b00000_00000001);
    core_done = 1'b0;
  endtask

  // Starts in an IDLE cycle with inputs already driven; returns one cycle after release.
  task automatic step(input string name, input logic [4:0] exp_rdy, input logic [5:0] exp_gnt,
                      input bit hold);
    logic [4:0] seen;
    logic [5:0] e;
    exp_q.push_back(exp_gnt);
    @(negedge clk);
    seen = rdy;
    check({name, " ready"}, 32'(rdy), 32'(exp_rdy));
    check({name, " idle"}, 32'({busy, grant}), 32'd0);
    @(posedge clk); #1;
    if (!hold) begin
      if (seen[0]) rsp_in_valid  = 1'b0;
      if (seen[1]) fwd_in_valid  = 1'b0;
      if (seen[2]) fence_valid   = 1'b0;
      if (seen[3]) flush_valid   = 1'b0;
      if (seen[4]) cpu_req_valid = 1'b0;
    end
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s scoreboard: got empty queue, required one entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " grant"}, 32'(grant), 32'(e));
      check({name, " busy"}, 32'(busy), 32'(e != 6'd0));
    end
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(13'b11111_00000001, 5'b00001, 6'b000001); // everything valid -> rsp
    tbl[1]  = mk(13'b01100_00000001, 5'b00010, 6'b000010); // fwd beats cpu
    tbl[2]  = mk(13'b01100_10000001, 5'b10000, 6'b100000); // fwd stalled -> cpu
    tbl[3]  = mk(13'b00100_01000001, 5'b00000, 6'b000000); // set conflict
    tbl[4]  = mk(13'b00100_00100001, 5'b00000, 6'b000000); // evict stall
    tbl[5]  = mk(13'b00100_00000011, 5'b00000, 6'b000000); // mshr full
    tbl[6]  = mk(13'b00100_00010001, 5'b10000, 6'b100000); // atomic does not block cpu
    tbl[7]  = mk(13'b00000_00001001, 5'b00000, 6'b000100); // ongoing flush, no ready
    tbl[8]  = mk(13'b00000_00101001, 5'b00000, 6'b000000); // ongoing flush + evict
    tbl[9]  = mk(13'b00011_00000001, 5'b00100, 6'b001000); // fence beats flush
    tbl[10] = mk(13'b00010_00000000, 5'b00000, 6'b000000); // flush, mshr busy
    tbl[11] = mk(13'b00010_00010001, 5'b00000, 6'b000000); // flush under atomic
    tbl[12] = mk(13'b00010_00000001, 5'b01000, 6'b010000); // flush alone
    tbl[13] = mk(13'b00101_00000101, 5'b00100, 6'b001000); // ongoing fence blocks cpu only
    tbl[14] = mk(13'b00101_00001001, 5'b00000, 6'b000100); // ofl beats fence/cpu
    tbl[15] = mk(13'b10000_11111110, 5'b00001, 6'b000001); // rsp ignores all blocks
    tbl[16] = mk(13'b00000_00000001, 5'b00000, 6'b000000); // nothing pending

    rst = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset grant", 32'(grant), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err", 32'(err_timeout), 32'd0);
    check("reset ready", 32'(rdy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      apply_in(tbl[i].in);
      step($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].gnt, 1'b0);
    end
    set_idle();

    // rsp, fwd, cpu served in priority order, one per core_done
    apply_in(13'b11100_00000001);
    step("seq1 rsp", 5'b00001, 6'b000001, 1'b0);
    step("seq1 fwd", 5'b00010, 6'b000010, 1'b0);
    step("seq1 cpu", 5'b10000, 6'b100000, 1'b0);
    set_idle();

    // fwd held continuously starves cpu until promotion
    apply_in(13'b01100_00000001);
    for (int i = 0; i < 8; i++) step($sformatf("starve fwd%0d", i), 5'b00010, 6'b000010, 1'b1);
    step("starve cpu", 5'b10000, 6'b100000, 1'b1);
    step("starve cleared", 5'b00010, 6'b000010, 1'b1);
    set_idle();

    // flush waits for mshr_empty
    apply_in(13'b00010_00000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush blocked ready", 32'(flush_ready), 32'd0);
      check("flush blocked grant", 32'(grant), 32'd0);
    end
    @(posedge clk); #1 mshr_empty = 1'b1;
    step("flush released", 5'b01000, 6'b010000, 1'b0);
    set_idle();

    // cpu blocked by set conflict for five cycles
    apply_in(13'b00100_01000001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("conflict ready", 32'(cpu_req_ready), 32'd0);
      check("conflict grant", 32'(grant), 32'd0);
    end
    @(posedge clk); #1 set_conflict = 1'b0;
    step("conflict released", 5'b10000, 6'b100000, 1'b0);
    set_idle();

    // busy timeout with core_done withheld
    cpu_req_valid = 1'b1;
    @(negedge clk);
    check("tmo ready", 32'(cpu_req_ready), 32'd1);
    @(posedge clk); #1 cpu_req_valid = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("tmo early", 32'(err_timeout), 32'd0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("tmo raised", 32'(err_timeout), 32'd1);
    check("tmo grant held", 32'(grant), 32'b100000);
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    @(negedge clk);
    check("tmo sticky", 32'(err_timeout), 32'd1);
    check("tmo released", 32'(grant), 32'd0);

    // reset while busy
    @(posedge clk); #1 fwd_in_valid = 1'b1;
    @(negedge clk);
    check("rst ready", 32'(fwd_in_ready), 32'd1);
    @(posedge clk); #1 fwd_in_valid = 1'b0;
    @(negedge clk);
    check("rst pre busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst grant", 32'(grant), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst err", 32'(err_timeout), 32'd0);
    @(posedge clk); #1 cpu_req_valid = 1'b1;
    step("post rst", 5'b10000, 6'b100000, 1'b0);
    set_idle();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
